// File: rtl/umi_pkg.sv
// UMI command field positions and opcode helpers
// shared by the host-port arbiter slice.
package umi_pkg;

  localparam logic [4:0] UMI_REQ_POSTED = 5'h05;
  localparam int UMI_OP_LSB = 0;
  localparam int UMI_OP_MSB = 4;
  localparam int UMI_EOM_BIT = 22;

  function automatic logic umi_needs_resp(
    input logic [4:0] opcode
  );
    return opcode != UMI_REQ_POSTED;
  endfunction

endpackage

// File: rtl/umi_arb_tagfifo.sv
// One-bit tag FIFO recording which requester owns
// each outstanding response, in issue order.
module umi_arb_tagfifo
  import umi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic nreset,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] ONE = 1;

  logic [PW:0]      wr_q, wr_d;
  logic [PW:0]      rd_q, rd_d;
  logic [DEPTH-1:0] mem_q, mem_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_q[PW-1:0]] = din;
      wr_d = wr_q + ONE;
    end
    if (pop) begin
      rd_d = rd_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

  assign dout  = mem_q[rd_q[PW-1:0]];
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PW] != rd_q[PW]) &&
                 (wr_q[PW-1:0] == rd_q[PW-1:0]);

endmodule

// File: rtl/umi_host_arb2.sv
// Two-to-one UMI host arbiter: round-robin per
// transaction, responses routed by an in-order tag FIFO.
module umi_host_arb2
  import umi_pkg::*;
#(
  parameter int CW    = 32,
  parameter int AW    = 64,
  parameter int DW    = 64,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          udev0_req_valid,
  input  logic [CW-1:0] udev0_req_cmd,
  input  logic [AW-1:0] udev0_req_dstaddr,
  input  logic [AW-1:0] udev0_req_srcaddr,
  input  logic [DW-1:0] udev0_req_data,
  output logic          udev0_req_ready,
  input  logic          udev1_req_valid,
  input  logic [CW-1:0] udev1_req_cmd,
  input  logic [AW-1:0] udev1_req_dstaddr,
  input  logic [AW-1:0] udev1_req_srcaddr,
  input  logic [DW-1:0] udev1_req_data,
  output logic          udev1_req_ready,
  output logic          udev0_resp_valid,
  output logic [CW-1:0] udev0_resp_cmd,
  output logic [AW-1:0] udev0_resp_dstaddr,
  output logic [AW-1:0] udev0_resp_srcaddr,
  output logic [DW-1:0] udev0_resp_data,
  input  logic          udev0_resp_ready,
  output logic          udev1_resp_valid,
  output logic [CW-1:0] udev1_resp_cmd,
  output logic [AW-1:0] udev1_resp_dstaddr,
  output logic [AW-1:0] udev1_resp_srcaddr,
  output logic [DW-1:0] udev1_resp_data,
  input  logic          udev1_resp_ready,
  output logic          uhost_req_valid,
  output logic [CW-1:0] uhost_req_cmd,
  output logic [AW-1:0] uhost_req_dstaddr,
  output logic [AW-1:0] uhost_req_srcaddr,
  output logic [DW-1:0] uhost_req_data,
  input  logic          uhost_req_ready,
  input  logic          uhost_resp_valid,
  input  logic [CW-1:0] uhost_resp_cmd,
  input  logic [AW-1:0] uhost_resp_dstaddr,
  input  logic [AW-1:0] uhost_resp_srcaddr,
  input  logic [DW-1:0] uhost_resp_data,
  output logic          uhost_resp_ready,
  output logic          err_orphan
);

  logic       last_q, last_d;
  logic       lock_q, lock_d;
  logic       owner_q, owner_d;
  logic       err_q, err_d;
  logic [1:0] nr, elig;
  logic       gnt, gnt_vld;
  logic       sel_eom, sel_nr;
  logic       commit, push, pop;
  logic       full, empty, head;

  // a requester is eligible unless it would
  // overflow the tag FIFO; posted writes pass
  always_comb begin
    nr[0] = umi_needs_resp(
      udev0_req_cmd[UMI_OP_MSB:UMI_OP_LSB]);
    nr[1] = umi_needs_resp(
      udev1_req_cmd[UMI_OP_MSB:UMI_OP_LSB]);
    elig[0] = udev0_req_valid & ~(full & nr[0]);
    elig[1] = udev1_req_valid & ~(full & nr[1]);
    gnt = 1'b0;
    unique case (1'b1)
      lock_q:
        gnt = owner_q;
      (!lock_q && elig == 2'b11):
        gnt = ~last_q;
      (!lock_q && elig == 2'b10):
        gnt = 1'b1;
      default:
        gnt = 1'b0;
    endcase
    gnt_vld = gnt ? elig[1] : elig[0];
  end

  assign uhost_req_valid   = gnt_vld;
  assign uhost_req_cmd     = gnt ? udev1_req_cmd
                                 : udev0_req_cmd;
  assign uhost_req_dstaddr = gnt ? udev1_req_dstaddr
                                 : udev0_req_dstaddr;
  assign uhost_req_srcaddr = gnt ? udev1_req_srcaddr
                                 : udev0_req_srcaddr;
  assign uhost_req_data    = gnt ? udev1_req_data
                                 : udev0_req_data;

  assign sel_eom = uhost_req_cmd[UMI_EOM_BIT];
  assign sel_nr  = gnt ? nr[1] : nr[0];
  assign commit  = gnt_vld & uhost_req_ready;
  assign push    = commit & sel_eom & sel_nr;

  assign udev0_req_ready = commit & ~gnt;
  assign udev1_req_ready = commit & gnt;

  // a stalled beat locks too, so the grant
  // cannot move before it commits
  always_comb begin
    last_d  = last_q;
    lock_d  = lock_q;
    owner_d = owner_q;
    if (commit) begin
      lock_d  = ~sel_eom;
      owner_d = gnt;
      if (sel_eom) last_d = gnt;
    end else if (gnt_vld) begin
      lock_d  = 1'b1;
      owner_d = gnt;
    end
    err_d = err_q | (uhost_resp_valid & empty);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      last_q  <= 1'b1;
      lock_q  <= 1'b0;
      owner_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      last_q  <= last_d;
      lock_q  <= lock_d;
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

  assign err_orphan = err_q;

  assign udev0_resp_valid = uhost_resp_valid & ~empty & ~head;
  assign udev1_resp_valid = uhost_resp_valid & ~empty & head;
  assign uhost_resp_ready = uhost_resp_valid &
    (empty | (head ? udev1_resp_ready : udev0_resp_ready));
  assign pop = uhost_resp_valid & ~empty & uhost_resp_ready &
               uhost_resp_cmd[UMI_EOM_BIT];

  assign udev0_resp_cmd     = uhost_resp_cmd;
  assign udev0_resp_dstaddr = uhost_resp_dstaddr;
  assign udev0_resp_srcaddr = uhost_resp_srcaddr;
  assign udev0_resp_data    = uhost_resp_data;
  assign udev1_resp_cmd     = uhost_resp_cmd;
  assign udev1_resp_dstaddr = uhost_resp_dstaddr;
  assign udev1_resp_srcaddr = uhost_resp_srcaddr;
  assign udev1_resp_data    = uhost_resp_data;

  umi_arb_tagfifo #(
    .DEPTH(DEPTH)
  ) u_tagfifo (
    .clk   (clk),
    .nreset(nreset),
    .push  (push),
    .din   (gnt),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_umi_host_arb2.sv
// Bench for umi_host_arb2: directed scenarios plus
// random traffic against a transaction-level model.
module tb_umi_host_arb2;

  localparam int CW = 32;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    rq_v, rq_rdy, rs_v, rs_rdy;
  logic [CW-1:0] rq_cmd [2];
  logic [AW-1:0] rq_dst [2];
  logic [AW-1:0] rq_src [2];
  logic [DW-1:0] rq_dat [2];
  logic [CW-1:0] r0_cmd, r1_cmd;
  logic [AW-1:0] r0_dst, r1_dst, r0_src, r1_src;
  logic [DW-1:0] r0_dat, r1_dat;
  logic          hq_v, hq_rdy, hs_v, hs_rdy, err;
  logic [CW-1:0] hq_cmd, hs_cmd;
  logic [AW-1:0] hq_dst, hq_src, hs_dst, hs_src;
  logic [DW-1:0] hq_dat, hs_dat;

  umi_host_arb2 #(
    .CW(CW), .AW(AW), .DW(DW), .DEPTH(DEPTH)
  ) dut (
    .clk               (clk),
    .nreset            (nreset),
    .udev0_req_valid   (rq_v[0]),
    .udev0_req_cmd     (rq_cmd[0]),
    .udev0_req_dstaddr (rq_dst[0]),
    .udev0_req_srcaddr (rq_src[0]),
    .udev0_req_data    (rq_dat[0]),
    .udev0_req_ready   (rq_rdy[0]),
    .udev1_req_valid   (rq_v[1]),
    .udev1_req_cmd     (rq_cmd[1]),
    .udev1_req_dstaddr (rq_dst[1]),
    .udev1_req_srcaddr (rq_src[1]),
    .udev1_req_data    (rq_dat[1]),
    .udev1_req_ready   (rq_rdy[1]),
    .udev0_resp_valid  (rs_v[0]),
    .udev0_resp_cmd    (r0_cmd),
    .udev0_resp_dstaddr(r0_dst),
    .udev0_resp_srcaddr(r0_src),
    .udev0_resp_data   (r0_dat),
    .udev0_resp_ready  (rs_rdy[0]),
    .udev1_resp_valid  (rs_v[1]),
    .udev1_resp_cmd    (r1_cmd),
    .udev1_resp_dstaddr(r1_dst),
    .udev1_resp_srcaddr(r1_src),
    .udev1_resp_data   (r1_dat),
    .udev1_resp_ready  (rs_rdy[1]),
    .uhost_req_valid   (hq_v),
    .uhost_req_cmd     (hq_cmd),
    .uhost_req_dstaddr (hq_dst),
    .uhost_req_srcaddr (hq_src),
    .uhost_req_data    (hq_dat),
    .uhost_req_ready   (hq_rdy),
    .uhost_resp_valid  (hs_v),
    .uhost_resp_cmd    (hs_cmd),
    .uhost_resp_dstaddr(hs_dst),
    .uhost_resp_srcaddr(hs_src),
    .uhost_resp_data   (hs_dat),
    .uhost_resp_ready  (hs_rdy),
    .err_orphan        (err)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t",
                  nm, act, exp, $time);
  endtask

  function automatic bit needs(input logic [CW-1:0] c);
    return c[4:0] != 5'h05;
  endfunction

  function automatic logic [CW-1:0] mk(input logic [4:0] op,
                                       input bit eom);
    logic [CW-1:0] c;
    c = '0;
    c[4:0] = op;
    c[22] = eom;
    return c;
  endfunction

  // transaction-level model state
  int m_last, m_cur, g, h;
  int m_tags[$];
  bit m_err, ev, e0, e1, mfull, er_rdy;
  logic [1:0] er_v, erdy;
  bit p_stall;
  logic [CW-1:0] p_cmd;
  logic [DW-1:0] p_dat;
  bit auto_on = 1'b0;
  int dev_q[$];
  logic [1:0] acc;
  bit racc;

  always @(negedge clk) begin
    if (!nreset) begin
      m_last = 1;
      m_cur = -1;
      m_tags.delete();
      m_err = 1'b0;
      p_stall = 1'b0;
    end
    mfull = (m_tags.size() == DEPTH);
    e0 = rq_v[0] && !(mfull && needs(rq_cmd[0]));
    e1 = rq_v[1] && !(mfull && needs(rq_cmd[1]));
    g = 0;
    if (m_cur >= 0) g = m_cur;
    else if (e0 && e1) g = 1 - m_last;
    else if (e1) g = 1;
    ev = (g == 1) ? e1 : e0;
    chk("req_valid", 64'(hq_v), 64'(ev));
    if (ev) begin
      chk("req_cmd", 64'(hq_cmd), 64'(rq_cmd[g]));
      chk("req_data", hq_dat, rq_dat[g]);
      chk("req_dst", hq_dst, rq_dst[g]);
      chk("req_src", hq_src, rq_src[g]);
    end
    erdy = (ev && hq_rdy) ? 2'(1 << g) : 2'b00;
    chk("req_ready", 64'(rq_rdy), 64'(erdy));
    er_v = 2'b00;
    er_rdy = 1'b0;
    h = 0;
    if (hs_v && m_tags.size() > 0) begin
      h = m_tags[0];
      er_v = 2'(1 << h);
      er_rdy = rs_rdy[h];
    end else if (hs_v) begin
      er_rdy = 1'b1;
    end
    chk("resp_valid", 64'(rs_v), 64'(er_v));
    chk("resp_ready", 64'(hs_rdy), 64'(er_rdy));
    chk("resp_bcast0", r0_dat, hs_dat);
    chk("resp_bcast1", 64'(r1_cmd), 64'(hs_cmd));
    chk("err_orphan", 64'(err), 64'(m_err));
    if (auto_on && hs_v)
      chk("resp_route", 64'(rs_v), 64'(2'b01 << hs_dat[56]));
    if (p_stall && nreset) begin
      chk("stall_cmd", 64'(hq_cmd), 64'(p_cmd));
      chk("stall_data", hq_dat, p_dat);
    end
    p_stall = hq_v && !hq_rdy && nreset;
    p_cmd = hq_cmd;
    p_dat = hq_dat;
    acc = rq_v & rq_rdy;
    racc = hs_v && hs_rdy;
    if (nreset) begin
      if (hs_v) begin
        if (m_tags.size() == 0) m_err = 1'b1;
        else if (rs_rdy[h] && hs_cmd[22]) void'(m_tags.pop_front());
      end
      if (ev) begin
        if (hq_rdy && rq_cmd[g][22]) begin
          m_last = g;
          m_cur = -1;
          if (needs(rq_cmd[g])) m_tags.push_back(g);
        end else begin
          m_cur = g;
        end
      end
      if (auto_on && hq_v && hq_rdy && hq_cmd[22] && needs(hq_cmd))
        dev_q.push_back(int'(hq_dat[63:56]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clr_inputs();
    rq_v = 2'b00;
    rs_rdy = 2'b00;
    hq_rdy = 1'b0;
    hs_v = 1'b0;
    hs_cmd = '0;
    hs_dst = '0;
    hs_src = '0;
    hs_dat = '0;
    for (int p = 0; p < 2; p++) begin
      rq_cmd[p] = '0;
      rq_dst[p] = '0;
      rq_src[p] = '0;
      rq_dat[p] = '0;
    end
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    clr_inputs();
    settle();
    tick();
    nreset = 1'b1;
  endtask

  // random requester / device state
  int left [2];
  logic [4:0] op [2];
  int seq = 0;
  int rleft = 0;
  int rport = 0;
  int p_req = 60;

  task automatic set_beat(input int p);
    logic [CW-1:0] c;
    c = $urandom;
    c[4:0] = op[p];
    c[22] = (left[p] == 1);
    rq_cmd[p] = c;
    rq_dat[p] = {8'(p), 24'h0, 32'(seq)};
    rq_dst[p] = {$urandom, $urandom};
    rq_src[p] = {$urandom, $urandom};
    seq++;
  endtask

  task automatic set_rbeat();
    logic [CW-1:0] c;
    c = $urandom;
    c[22] = (rleft == 1);
    hs_cmd = c;
    hs_dat = {8'(rport), 24'h0, 32'(seq)};
    hs_dst = {$urandom, $urandom};
    hs_src = {$urandom, $urandom};
    seq++;
  endtask

  task automatic rand_step();
    int k;
    for (int p = 0; p < 2; p++) begin
      if (acc[p]) begin
        left[p]--;
        if (left[p] > 0) set_beat(p);
        else rq_v[p] = 1'b0;
      end
      if (!rq_v[p] && p_req > $urandom_range(99)) begin
        k = $urandom_range(2);
        op[p] = (k == 0) ? 5'h01 : (k == 1) ? 5'h05 : 5'h03;
        left[p] = (k == 0) ? 1 : $urandom_range(3, 1);
        set_beat(p);
        rq_v[p] = 1'b1;
      end
    end
    if (racc) begin
      rleft--;
      if (rleft == 0) hs_v = 1'b0;
      else set_rbeat();
    end
    if (!hs_v && dev_q.size() > 0 && $urandom_range(1) == 1) begin
      rport = dev_q.pop_front();
      rleft = $urandom_range(2, 1);
      set_rbeat();
      hs_v = 1'b1;
    end
    hq_rdy = ($urandom_range(9) < 7);
    rs_rdy[0] = ($urandom_range(9) < 7);
    rs_rdy[1] = ($urandom_range(9) < 7);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bit done;
    clr_inputs();
    #1;
    do_reset();
    settle();
    chk("rst_req_valid", 64'(hq_v), 64'd0);
    chk("rst_req_ready", 64'(rq_rdy), 64'd0);
    chk("rst_resp_valid", 64'(rs_v), 64'd0);
    chk("rst_resp_ready", 64'(hs_rdy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    tick();

    // alternation, then tag FIFO full
    rq_v = 2'b11;
    rq_cmd[0] = mk(5'h01, 1'b1);
    rq_cmd[1] = mk(5'h01, 1'b1);
    rq_dat[0] = 64'hA0;
    rq_dat[1] = 64'hB1;
    hq_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("alt_grant", hq_dat, (k % 2 == 1) ? 64'hB1 : 64'hA0);
      chk("alt_ready", 64'(rq_rdy),
          (k % 2 == 1) ? 64'd2 : 64'd1);
      tick();
    end
    settle();
    chk("full_stall_v", 64'(hq_v), 64'd0);
    chk("full_stall_rdy", 64'(rq_rdy), 64'd0);
    tick();
    rq_cmd[1] = mk(5'h05, 1'b1);
    settle();
    chk("posted_pass", 64'(hq_v), 64'd1);
    chk("posted_port", 64'(rq_rdy), 64'd2);
    tick();
    rq_v = 2'b01;
    hs_v = 1'b1;
    hs_cmd = mk(5'h02, 1'b1);
    rs_rdy = 2'b11;
    settle();
    chk("pop_route", 64'(rs_v), 64'd1);
    chk("still_full", 64'(hq_v), 64'd0);
    tick();
    settle();
    chk("release", 64'(rq_rdy), 64'd1);
    chk("route2", 64'(rs_v), 64'd2);
    tick();
    rq_v = 2'b00;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("drain_route", 64'(rs_v), (k == 1) ? 64'd2 : 64'd1);
      tick();
    end
    hs_v = 1'b0;

    // multi-beat lock
    do_reset();
    rq_v = 2'b11;
    rq_cmd[1] = mk(5'h01, 1'b1);
    rq_dat[1] = 64'hB1;
    rq_cmd[0] = mk(5'h03, 1'b0);
    rq_dat[0] = 64'hC0;
    hq_rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk("burst_grant", hq_dat,
          (c < 3) ? 64'hC0 + 64'(c) : 64'hB1);
      tick();
      if (c < 2) begin
        rq_cmd[0] = mk(5'h03, c == 1);
        rq_dat[0] = 64'hC0 + 64'(c + 1);
      end else if (c == 2) begin
        rq_cmd[0] = mk(5'h01, 1'b1);
        rq_dat[0] = 64'hD0;
      end
    end

    // grant held while stalled
    do_reset();
    rq_v = 2'b10;
    rq_cmd[1] = mk(5'h01, 1'b1);
    rq_dat[1] = 64'hB1;
    settle();
    chk("hold_first", hq_dat, 64'hB1);
    tick();
    rq_v = 2'b11;
    rq_cmd[0] = mk(5'h01, 1'b1);
    rq_dat[0] = 64'hA0;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("hold_port", hq_dat, 64'hB1);
      chk("hold_rdy", 64'(rq_rdy), 64'd0);
      tick();
    end
    hq_rdy = 1'b1;
    settle();
    chk("hold_commit", 64'(rq_rdy), 64'd2);
    tick();
    settle();
    chk("hold_next", hq_dat, 64'hA0);
    tick();

    // orphan response
    do_reset();
    hs_v = 1'b1;
    hs_cmd = mk(5'h02, 1'b1);
    settle();
    chk("orph_rdy", 64'(hs_rdy), 64'd1);
    chk("orph_v", 64'(rs_v), 64'd0);
    tick();
    hs_v = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("orph_err", 64'(err), 64'd1);
      tick();
    end

    // reset with outstanding tags
    do_reset();
    settle();
    chk("rst_clr_err", 64'(err), 64'd0);
    tick();
    rq_v = 2'b11;
    rq_cmd[0] = mk(5'h01, 1'b1);
    rq_cmd[1] = mk(5'h01, 1'b1);
    hq_rdy = 1'b1;
    settle();
    tick();
    settle();
    tick();
    do_reset();
    hs_v = 1'b1;
    hs_cmd = mk(5'h02, 1'b1);
    rs_rdy = 2'b11;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("stale_v", 64'(rs_v), 64'd0);
      chk("stale_rdy", 64'(hs_rdy), 64'd1);
      if (k == 0) chk("stale_err_pre", 64'(err), 64'd0);
      tick();
    end
    hs_v = 1'b0;
    settle();
    chk("stale_err", 64'(err), 64'd1);
    tick();

    // random traffic
    do_reset();
    dev_q.delete();
    left[0] = 0;
    left[1] = 0;
    rleft = 0;
    auto_on = 1'b1;
    p_req = 60;
    for (int k = 0; k < 3000; k++) begin
      rand_step();
      settle();
      tick();
    end
    p_req = 0;
    done = 1'b0;
    for (int k = 0; k < 2000 && !done; k++) begin
      rand_step();
      settle();
      done = (rq_v == 2'b00) && !hs_v &&
             (dev_q.size() == 0) && (m_tags.size() == 0);
      tick();
    end
    chk("drain_done", 64'(done), 64'd1);
    auto_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/umi_host_arb2.md
# umi_host_arb2

Two-to-one UMI host-port arbiter. It lets two UMI requesters share a single UMI host link into one device, for example two `axilite2umi` converters feeding one `umi_memagent`. Requests are granted round-robin at transaction granularity. Responses are returned to the originating requester through an in-order tag FIFO, which relies on the downstream device responding in request order.

## Interface
Parameters:
- CW, 32, UMI command width
- AW, 64, UMI address width
- DW, 64, UMI data width
- DEPTH, 4, maximum outstanding response-bearing transactions; power of two, ≥2

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- udev{0,1}_req_valid  in  1  requester n request valid
- udev{0,1}_req_cmd / _dstaddr / _srcaddr / _data  in  CW/AW/AW/DW  requester n request fields
- udev{0,1}_req_ready  out  1  requester n request accepted
- udev{0,1}_resp_valid  out  1  response to requester n valid
- udev{0,1}_resp_cmd / _dstaddr / _srcaddr / _data  out  CW/AW/AW/DW  response fields (broadcast to both requesters)
- udev{0,1}_resp_ready  in  1  requester n accepts response
- uhost_req_valid/_cmd/_dstaddr/_srcaddr/_data  out  1/CW/AW/AW/DW  shared downstream request
- uhost_req_ready  in  1
- uhost_resp_valid/_cmd/_dstaddr/_srcaddr/_data  in  1/CW/AW/AW/DW  downstream response
- uhost_resp_ready  out  1
- err_orphan  out  1  sticky flag: a response arrived with no outstanding tag

## Operation
- Opcode is cmd[4:0]; EOM is cmd[22]. A request needs a response unless opcode == 5'h05 (posted write).
- Arbitration: when unlocked, grant goes to the single valid requester. If both are valid, grant goes to the requester that did not win the last completed transaction (register `last`, reset = 1 so port 0 wins first).
- Lock: on a commit (uhost_req_valid & uhost_req_ready) with EOM=0, set `lock` and `owner` = granted port. While locked, only `owner` is granted. Lock clears on the owner's EOM commit.
- The grant is never withdrawn while uhost_req_valid=1 and ready=0; the granted port is held stable until commit.
- Tag FIFO: on an EOM commit of a response-bearing request, push the port id. Gate: if the FIFO is full and the granted request needs a response, uhost_req_valid=0 and both udev req_ready=0. Posted requests still pass.
- Response routing: the head tag selects the port. udevX_resp_valid = uhost_resp_valid & (head==X) & ~empty; uhost_resp_ready = selected port's resp_ready. Pop on response commit with EOM=1.
- Orphan: if uhost_resp_valid is asserted with the FIFO empty, drive uhost_resp_ready=1, drop the beat, and set err_orphan. err_orphan clears only on reset.
- Simultaneous push and pop in one cycle is allowed; occupancy is unchanged. Push when full cannot occur (gated). Pop when empty cannot occur (orphan path).
- Pointers are log2(DEPTH)+1 bits wide and wrap naturally. full = MSBs differ and low bits equal.

## Timing
- Request and response datapaths are combinational: zero cycles of latency, no registers in the data path.
- Registered state: `last`, `lock`, `owner`, FIFO pointers and storage, err_orphan.
- Reset values: lock=0, owner=0, last=1, FIFO empty, err_orphan=0. All valid and ready outputs are 0 while no input valid is asserted.
- A non-granted requester sees req_ready=0.
- A tag pushed at edge N is poppable by a response committing in cycle N+1 or later. A same-cycle request and response cannot reference each other.
- Reset mid-transaction discards the lock and all outstanding tags. Downstream responses to transactions issued before reset are then treated as orphans.

## Structure
- Shared package `umi_pkg`: opcode constants (UMI_REQ_POSTED = 5'h05), the command field positions (OPCODE [4:0], EOM bit 22), and a `umi_needs_resp()` function.
- One sub-module, `umi_arb_tagfifo`: a 1-bit-wide synchronous FIFO with DEPTH entries and full/empty outputs. The arbiter and muxes stay in the top module.

## Test plan
- Both ports hold a single-beat read (opcode 01, EOM=1) continuously, uhost_req_ready=1 → grants alternate 0,1,0,1; responses are routed to the matching ports in the same order.
- Port 0 sends a 3-beat write (EOM on beat 3) while port 1 is valid throughout → all 3 beats of port 0 go out contiguously, then port 1 is granted.
- DEPTH=4 with uhost_resp_valid held 0: issue 4 reads → the 5th read stalls with req_ready=0, while a posted write (opcode 05) from the other port still passes; one response pop releases the stall the next cycle.
- Hold uhost_req_ready=0 for 5 cycles with both ports valid → the granted port and its data stay stable; no switch occurs before commit.
- Inject uhost_resp_valid with the FIFO empty → uhost_resp_ready=1, no udev resp_valid, err_orphan=1 until nreset.
- Assert nreset low with 2 tags outstanding → FIFO empty, lock=0, err_orphan=0; the next two stale responses set err_orphan.
